adc_model: RTL and testbench

Synthesisable behavioural ADC that sits directly upstream of the trigger/sample-capture controller. It answers that controller's `req` with a converted 8-bit sample on `dat` and a `rdy` flag, after a fixed conversion latency, using a four-phase handshake. Samples come from an internal 32-entry sine table that advances one step per completed conversion. The block gives benches and FPGA bring-up a deterministic, repeatable signal source.

---
 rtl/adc_pkg.sv | 35 +++
 rtl/adc_lfsr.sv | 24 ++
 rtl/adc_model.sv | 106 ++++++++++
 tb/tb_adc_model.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the behavioural ADC: FSM states, sine table, LFSR constants.
// The LFSR constants and sat_add are only used when ADC_NOISE_EN is defined.
package adc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StReady
    } adc_state_e;

    // round(128 + 127*sin(2*pi*k/32))
    localparam logic [7:0] SineTable [32] = '{
        8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
        8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
        8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
        8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
    };

    localparam logic [7:0] LfsrSeed = 8'hA5;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LfsrTaps = 8'hB8;

    // base plus a signed 4-bit offset, clamped to 0..255
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [3:0] offs);
        logic signed [9:0] sum;
        sum = $signed({2'b00, base}) + $signed({{6{offs[3]}}, offs});
        if (sum < 10'sd0) begin
            return 8'h00;
        end else if (sum > 10'sd255) begin
            return 8'hFF;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/adc_lfsr.sv
// 8-bit Fibonacci LFSR noise source; loads the seed on reset and steps when enabled.
// Instantiated only when ADC_NOISE_EN is defined.
module adc_lfsr
    import adc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] state
);

    logic [7:0] state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LfsrSeed;
        end else if (en) begin
            state_q <= {state_q[6:0], ^(state_q & LfsrTaps)};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/adc_model.sv
// Behavioural ADC answering a four-phase req/rdy handshake with sine-table samples.
// Define ADC_NOISE_EN to add saturated LFSR noise to each sample.
module adc_model
    import adc_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 4,
    parameter int unsigned TABLE_STEP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       rdy,
    output logic [7:0] dat,
    output logic       busy,
    output logic       abort
);

    localparam logic [7:0] CntLoad = 8'(CONV_CYCLES - 1);
    localparam logic [4:0] IdxStep = 5'(TABLE_STEP);

    adc_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] dat_q, dat_d;
    logic       rdy_q, busy_q, abort_q, abort_d;
    logic [7:0] sample;

`ifdef ADC_NOISE_EN
    logic [7:0] lfsr_state;
    logic       conv_done;

    // Noise uses the LFSR value present at the completing edge, then the LFSR steps
    assign conv_done = (state_q == StConvert) && req && (cnt_q == 8'd0);

    adc_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (conv_done),
        .state (lfsr_state)
    );

    assign sample = sat_add(SineTable[idx_q], lfsr_state[3:0]);
`else
    assign sample = SineTable[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        abort_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StConvert;
                    cnt_d   = CntLoad;
                end
            end
            StConvert: begin
                if (!req) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = StReady;
                    dat_d   = sample;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StReady: begin
                if (!req) begin
                    state_d = StIdle;
                    idx_d   = idx_q + IdxStep;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 5'd0;
            dat_q   <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            rdy_q   <= (state_d == StReady);
            busy_q  <= (state_d == StConvert);
            abort_q <= abort_d;
        end
    end

    assign rdy   = rdy_q;
    assign dat   = dat_q;
    assign busy  = busy_q;
    assign abort = abort_q;

endmodule

// File: tb/tb_adc_model.sv
// Self-checking bench for adc_model: directed handshakes plus randomized req/reset traffic
// compared every cycle against a behavioural model (honours ADC_NOISE_EN).
module tb_adc_model;

    localparam int unsigned CONV = 4;
    localparam int unsigned STEP = 1;
`ifdef ADC_NOISE_EN
    localparam int FIRST = 133;
`else
    localparam int FIRST = 128;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       rdy, busy, abort;
    logic [7:0] dat;

    adc_model #(
        .CONV_CYCLES (CONV),
        .TABLE_STEP  (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .rdy   (rdy),
        .dat   (dat),
        .busy  (busy),
        .abort (abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: phase flags, cycles since request accepted, table position
    bit         m_conv, m_ready;
    int         m_age, m_k;
    logic       m_rdy, m_busy, m_abort;
    logic [7:0] m_dat;
    logic [7:0] m_lfsr;

    function automatic int sine_ref(input int k);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic logic [7:0] model_sample();
        int s;
        s = sine_ref(m_k);
`ifdef ADC_NOISE_EN
        begin
            int n;
            n = int'(m_lfsr[3:0]);
            if (n > 7) n = n - 16;
            s = s + n;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
        end
`endif
        return 8'(s);
    endfunction

    task automatic model_reset();
        m_conv  = 0;
        m_ready = 0;
        m_age   = 0;
        m_k     = 0;
        m_rdy   = 1'b0;
        m_busy  = 1'b0;
        m_abort = 1'b0;
        m_dat   = 8'h00;
        m_lfsr  = 8'hA5;
    endtask

    task automatic model_step(input logic r);
        m_abort = 1'b0;
        if (m_ready) begin
            if (!r) begin
                m_ready = 0;
                m_rdy   = 1'b0;
                m_k     = (m_k + STEP) % 32;
            end
        end else if (m_conv) begin
            if (!r) begin
                m_conv  = 0;
                m_busy  = 1'b0;
                m_abort = 1'b1;
            end else begin
                m_age = m_age + 1;
                if (m_age == CONV) begin
                    m_conv  = 0;
                    m_busy  = 1'b0;
                    m_ready = 1;
                    m_rdy   = 1'b1;
                    m_dat   = model_sample();
                    m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                end
            end
        end else if (r) begin
            m_conv = 1;
            m_age  = 0;
            m_busy = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rdy", 32'(rdy), 32'(m_rdy));
        chk("dat", 32'(dat), 32'(m_dat));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("abort", 32'(abort), 32'(m_abort));
    endtask

    task automatic cyc(input logic r);
        @(negedge clk);
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed entirely within the clock-low phase
    task automatic pulse_reset();
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2;
        reset = 1'b0;
    endtask

    task automatic handshake(output int lat, output int busy_n, output logic [7:0] d);
        cyc(1'b1);
        busy_n = (busy === 1'b1) ? 1 : 0;
        lat    = 0;
        while (rdy !== 1'b1 && lat < 60) begin
            cyc(1'b1);
            lat++;
            if (busy === 1'b1) busy_n++;
        end
        if (lat >= 60) chk("hs_timeout", 32'(rdy), 32'd1);
        d = dat;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, bn;
        logic [7:0] d, d0;
        logic       r;

        model_reset();
        #1;
        check_all();
        chk("init_rdy", 32'(rdy), 32'd0);
        chk("init_dat", 32'(dat), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First conversion latency, busy width and value
        handshake(lat, bn, d);
        chk("first_lat", 32'(lat), 32'(CONV));
        chk("first_busy", 32'(bn), 32'(CONV));
        chk("first_dat", 32'(d), 32'(FIRST));
        cyc(1'b0);

        // Full table sweep and wrap
        for (int h = 2; h <= 33; h++) begin
            handshake(lat, bn, d);
            chk("hs_lat", 32'(lat), 32'(CONV));
`ifndef ADC_NOISE_EN
            if (h == 9)  chk("k8_dat", 32'(d), 32'hFF);
            if (h == 25) chk("k24_dat", 32'(d), 32'd1);
            if (h == 33) chk("wrap_dat", 32'(d), 32'h80);
`endif
            cyc(1'b0);
        end

        // Abort two cycles into CONVERT
        d0 = dat;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        chk("abort_pulse", 32'(abort), 32'd1);
        chk("abort_rdy", 32'(rdy), 32'd0);
        chk("abort_dat", 32'(dat), 32'(d0));
        cyc(1'b0);
        chk("abort_len", 32'(abort), 32'd0);
        handshake(lat, bn, d);
`ifndef ADC_NOISE_EN
        chk("post_abort_dat", 32'(d), 32'd153);
`endif

        // req held after READY: no second conversion
        for (int i = 0; i < 20; i++) cyc(1'b1);
        chk("hold_rdy", 32'(rdy), 32'd1);
        chk("hold_dat", 32'(dat), 32'(d));
        cyc(1'b0);

        // Reset in CONVERT, then in READY
        cyc(1'b1);
        cyc(1'b1);
        pulse_reset();
        handshake(lat, bn, d);
        chk("rst_conv_dat", 32'(d), 32'(FIRST));
        pulse_reset();
        handshake(lat, bn, d);
        chk("rst_ready_dat", 32'(d), 32'(FIRST));
        cyc(1'b0);

        // Randomized req levels with occasional asynchronous resets
        r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
                r = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) r = ~r;
            cyc(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
